// File: rtl/hier_rr_arb_if.sv
// rtl/hier_rr_arb_if.sv - request matrix / grant handshake bundle for hier_rr_arb
interface hier_rr_arb_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic                       enable;
    logic [ROWS-1:0][COLS-1:0]  req_i;
    logic                       gnt_ready_i;
    logic                       gnt_valid_o;
    logic [ROWS-1:0]            x_gnt_o;
    logic [COLS-1:0]            y_gnt_o;
    logic [RW-1:0]              x_addr_o;
    logic [CW-1:0]              y_addr_o;
    logic                       grp_release_o;

    modport slave (
        input  enable, req_i, gnt_ready_i,
        output gnt_valid_o, x_gnt_o, y_gnt_o, x_addr_o, y_addr_o, grp_release_o
    );

    modport master (
        output enable, req_i, gnt_ready_i,
        input  gnt_valid_o, x_gnt_o, y_gnt_o, x_addr_o, y_addr_o, grp_release_o
    );
endinterface

// File: rtl/hier_rr_arb.sv
// rtl/hier_rr_arb.sv - round-robin row selection with per-row column snapshot and grant handshake
module hier_rr_arb #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter bit HOLD_ROW = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    hier_rr_arb_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [RW-1:0]   ptr_q, ptr_d;
    logic [COLS-1:0] snap_q, snap_d;
    logic            valid_q, valid_d;
    logic [ROWS-1:0] xg_q, xg_d;
    logic [COLS-1:0] yg_q, yg_d;
    logic [RW-1:0]   xa_q, xa_d;
    logic [CW-1:0]   ya_q, ya_d;
    logic            rel_q, rel_d;

    logic            found;
    logic [RW-1:0]   sel;
    logic [COLS-1:0] rem;
    logic [CW-1:0]   c_new;
    int              idx;

    function automatic logic [CW-1:0] lowest(input logic [COLS-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (v[i]) r = CW'(i);
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        ptr_d   = ptr_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        xg_d    = xg_q;
        yg_d    = yg_q;
        xa_d    = xa_q;
        ya_d    = ya_q;
        rel_d   = 1'b0;
        found   = 1'b0;
        sel     = ptr_q;
        idx     = 0;
        c_new   = '0;

        // First requesting row at or after the pointer, wrapping.
        for (int i = 0; i < ROWS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= ROWS) idx = idx - ROWS;
            if (!found && (|bus.req_i[RW'(idx)])) begin
                found = 1'b1;
                sel   = RW'(idx);
            end
        end

        // yg_q is the one-hot of the column being presented.
        rem = snap_q & ~yg_q;

        case (state_q)
            IDLE: begin
                if (bus.enable && found) begin
                    c_new   = lowest(bus.req_i[sel]);
                    state_d = GRANT;
                    row_d   = sel;
                    snap_d  = bus.req_i[sel];
                    valid_d = 1'b1;
                    xg_d    = ROWS'(1) << sel;
                    xa_d    = sel;
                    yg_d    = COLS'(1) << c_new;
                    ya_d    = c_new;
                end
            end
            GRANT: begin
                if (bus.gnt_ready_i) begin
                    if (HOLD_ROW && (rem != '0) && bus.enable) begin
                        c_new  = lowest(rem);
                        snap_d = rem;
                        yg_d   = COLS'(1) << c_new;
                        ya_d   = c_new;
                    end else begin
                        state_d = RELEASE;
                        snap_d  = '0;
                        valid_d = 1'b0;
                        xg_d    = '0;
                        yg_d    = '0;
                        xa_d    = '0;
                        ya_d    = '0;
                        rel_d   = 1'b1;
                        ptr_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            ptr_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            xg_q    <= '0;
            yg_q    <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            ptr_q   <= ptr_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            xg_q    <= xg_d;
            yg_q    <= yg_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            rel_q   <= rel_d;
        end
    end

    assign bus.gnt_valid_o   = valid_q;
    assign bus.x_gnt_o       = xg_q;
    assign bus.y_gnt_o       = yg_q;
    assign bus.x_addr_o      = xa_q;
    assign bus.y_addr_o      = ya_q;
    assign bus.grp_release_o = rel_q;
endmodule

// File: tb/tb_hier_rr_arb.sv
// tb/tb_hier_rr_arb.sv - directed vector bench for hier_rr_arb (HOLD_ROW=1 and HOLD_ROW=0)
module tb_hier_rr_arb;
    logic clk;
    logic reset;

    hier_rr_arb_if #(.ROWS(4), .COLS(4)) a_if ();
    hier_rr_arb_if #(.ROWS(4), .COLS(4)) b_if ();

    hier_rr_arb #(.ROWS(4), .COLS(4), .HOLD_ROW(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave)
    );
    hier_rr_arb #(.ROWS(4), .COLS(4), .HOLD_ROW(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        en;
        logic        rdy;
        logic [15:0] req;
        logic        ev;
        int          exa;
        int          eya;
        logic        erel;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rn, input logic en, input logic rdy, input logic [15:0] req,
                       input logic ev, input int exa, input int eya, input logic erel);
        vec_t t;
        t.rn = rn; t.en = en; t.rdy = rdy; t.req = req;
        t.ev = ev; t.exa = exa; t.eya = eya; t.erel = erel;
        tbl.push_back(t);
    endtask

    task automatic check(input string nm, input logic v, input logic [3:0] x, input logic [3:0] y,
                         input logic [1:0] xa, input logic [1:0] ya, input logic rel,
                         input logic ev, input int exa, input int eya, input logic erel);
        logic [3:0] ex, ey;
        logic [1:0] exa2, eya2;
        ex   = ev ? 4'(1 << exa) : 4'b0;
        ey   = ev ? 4'(1 << eya) : 4'b0;
        exa2 = ev ? 2'(exa) : 2'b0;
        eya2 = ev ? 2'(eya) : 2'b0;
        n_vec++;
        if (v !== ev || x !== ex || y !== ey || xa !== exa2 || ya !== eya2 || rel !== erel) begin
            n_bad++;
            $display("FAIL %s: got v=%0b x=%b y=%b xa=%0d ya=%0d rel=%0b, expected v=%0b x=%b y=%b xa=%0d ya=%0d rel=%0b",
                     nm, v, x, y, xa, ya, rel, ev, ex, ey, exa2, eya2, erel);
        end
    endtask

    task automatic step_b(input string nm, input logic ev, input int exa, input int eya, input logic erel);
        @(negedge clk);
        @(posedge clk);
        #1;
        check(nm, b_if.gnt_valid_o, b_if.x_gnt_o, b_if.y_gnt_o, b_if.x_addr_o, b_if.y_addr_o,
              b_if.grp_release_o, ev, exa, eya, erel);
    endtask

    initial begin
        reset = 1'b0;
        a_if.enable = 1'b0; a_if.req_i = '0; a_if.gnt_ready_i = 1'b0;
        b_if.enable = 1'b0; b_if.req_i = '0; b_if.gnt_ready_i = 1'b0;

        // rn en rdy req | valid row col release
        add(0,1,1,16'h000F, 0,0,0,0);
        add(0,1,1,16'h000F, 0,0,0,0);
        add(1,1,1,16'h000F, 1,0,0,0);
        add(1,1,1,16'h000F, 1,0,1,0);
        add(1,1,1,16'h000F, 1,0,2,0);
        add(1,1,1,16'h000F, 1,0,3,0);
        add(1,1,1,16'h000F, 0,0,0,1);
        add(1,1,1,16'h0000, 0,0,0,0);
        add(1,1,1,16'h000F, 1,0,0,0);
        add(1,1,1,16'h000F, 1,0,1,0);
        add(0,1,1,16'h000F, 0,0,0,0);
        add(1,1,1,16'h0000, 0,0,0,0);
        // single-row burst; req changes mid-group are ignored
        add(1,1,1,16'h000D, 1,0,0,0);
        add(1,1,1,16'h0002, 1,0,2,0);
        add(1,1,1,16'h0000, 1,0,3,0);
        add(1,1,1,16'h0000, 0,0,0,1);
        add(1,1,1,16'h0000, 0,0,0,0);
        add(1,1,1,16'h0000, 0,0,0,0);
        // rows 1 and 2 alternate
        add(1,1,1,16'h0AA0, 1,1,1,0);
        add(1,1,1,16'h0AA0, 1,1,3,0);
        add(1,1,1,16'h0AA0, 0,0,0,1);
        add(1,1,1,16'h0AA0, 0,0,0,0);
        add(1,1,1,16'h0AA0, 1,2,1,0);
        add(1,1,1,16'h0AA0, 1,2,3,0);
        add(1,1,1,16'h0AA0, 0,0,0,1);
        add(1,1,1,16'h0AA0, 0,0,0,0);
        add(1,1,1,16'h0AA0, 1,1,1,0);
        add(1,1,1,16'h0AA0, 1,1,3,0);
        add(1,1,1,16'h0000, 0,0,0,1);
        add(1,1,1,16'h0000, 0,0,0,0);
        // backpressure
        add(1,1,0,16'h0003, 1,0,0,0);
        add(1,1,0,16'h0003, 1,0,0,0);
        add(1,1,0,16'h0003, 1,0,0,0);
        add(1,1,0,16'h0003, 1,0,0,0);
        add(1,1,1,16'h0003, 1,0,1,0);
        add(1,1,1,16'h0000, 0,0,0,1);
        add(1,1,1,16'h0000, 0,0,0,0);
        // enable drop while c1 stalled
        add(1,1,0,16'h000F, 1,0,0,0);
        add(1,1,1,16'h000F, 1,0,1,0);
        add(1,0,0,16'h000F, 1,0,1,0);
        add(1,0,0,16'h000F, 1,0,1,0);
        add(1,0,1,16'h000F, 0,0,0,1);
        add(1,0,1,16'h000F, 0,0,0,0);
        add(1,0,1,16'h000F, 0,0,0,0);
        add(1,1,1,16'h000F, 1,0,0,0);
        add(1,1,1,16'h0000, 1,0,1,0);
        add(1,0,1,16'h0000, 0,0,0,1);
        add(1,0,1,16'h0000, 0,0,0,0);
        // last row wraps the pointer to row 0
        add(1,1,1,16'h1000, 1,3,0,0);
        add(1,1,1,16'h1000, 0,0,0,1);
        add(1,1,1,16'h1000, 0,0,0,0);
        add(1,1,1,16'h1001, 1,0,0,0);
        add(1,1,1,16'h0000, 0,0,0,1);
        add(1,1,1,16'h0000, 0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset            = tbl[i].rn;
            a_if.enable      = tbl[i].en;
            a_if.gnt_ready_i = tbl[i].rdy;
            a_if.req_i       = tbl[i].req;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), a_if.gnt_valid_o, a_if.x_gnt_o, a_if.y_gnt_o,
                  a_if.x_addr_o, a_if.y_addr_o, a_if.grp_release_o,
                  tbl[i].ev, tbl[i].exa, tbl[i].eya, tbl[i].erel);
        end

        // one grant per row selection
        @(negedge clk);
        b_if.enable      = 1'b1;
        b_if.gnt_ready_i = 1'b1;
        b_if.req_i       = 16'h8003;
        @(posedge clk);
        #1;
        check("hold0_r0c0", b_if.gnt_valid_o, b_if.x_gnt_o, b_if.y_gnt_o, b_if.x_addr_o,
              b_if.y_addr_o, b_if.grp_release_o, 1, 0, 0, 0);
        step_b("hold0_rel0", 0, 0, 0, 1);
        step_b("hold0_idle0", 0, 0, 0, 0);
        step_b("hold0_r3c3", 1, 3, 3, 0);
        step_b("hold0_rel3", 0, 0, 0, 1);
        step_b("hold0_idle3", 0, 0, 0, 0);
        step_b("hold0_r0c0_again", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
